// File: rtl/demux1x4_buf_pkg.sv
// Lane count, select width and lane-slice indexing shared by the mux/demux family.
package demux1x4_buf_pkg;
   localparam int NUM_LANES = 4;
   localparam int SEL_W     = 2;

   // Lowest bit of lane k in a packed bus of w-bit lanes.
   function automatic int lane_lo(input int k, input int w);
      return k * w;
   endfunction
endpackage

// File: rtl/demux1x4_buf_lane_buf.sv
// One-entry lane holding register; latency 1 from load to full.
// A load wins over a same-cycle drain, so a full lane can be refilled without a bubble.
module lane_buf #(
   parameter int size = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic [size-1:0] din,
   input  logic            drain,
   output logic [size-1:0] dout,
   output logic            full
);
   logic [size-1:0] data_q, data_d;
   logic            full_q, full_d;

   always_comb begin
      data_d = data_q;
      full_d = full_q;
      if (load) begin
         data_d = din;
         full_d = 1'b1;
      end else if (drain) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         full_q <= full_d;
      end
   end

   assign dout = data_q;
   assign full = full_q;
endmodule

// File: rtl/demux1x4_buf.sv
// Routes one input word to one of four buffered lanes; latency 1 to yValid.
// inReady tracks only the selected lane, so a stalled lane never blocks the others.
module demux1x4_buf
   import demux1x4_buf_pkg::*;
#(
   parameter int size = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      inValid,
   output logic                      inReady,
   input  logic [size-1:0]           inputVal,
   output logic [size*NUM_LANES-1:0] y,
   output logic [NUM_LANES-1:0]      yValid,
   input  logic [NUM_LANES-1:0]      yReady
);
   logic [NUM_LANES-1:0] lane_full;
   logic [NUM_LANES-1:0] lane_load;
   logic [NUM_LANES-1:0] lane_drain;
   logic [size-1:0]      lane_dout [NUM_LANES];
   logic                 in_xfer;

   // Selected lane can take a word if empty or being drained this same edge.
   assign inReady = ~reset & (~lane_full[sel] | yReady[sel]);
   assign in_xfer = inValid & inReady;
   assign yValid  = lane_full;

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      assign lane_load[k]  = in_xfer & (sel == SEL_W'(k));
      assign lane_drain[k] = lane_full[k] & yReady[k];

      lane_buf #(.size(size)) u_lane (
         .clk   (clk),
         .reset (reset),
         .load  (lane_load[k]),
         .din   (inputVal),
         .drain (lane_drain[k]),
         .dout  (lane_dout[k]),
         .full  (lane_full[k])
      );

      assign y[lane_lo(k, size) +: size] = lane_dout[k];
   end
endmodule
